sample04_result_fifo: RTL and testbench

Downstream capture stage for the `sample04` scheduling circuit. It samples the combinational results `r`, `s`, `t` when the upstream driver marks them valid and buffers them as 3-bit words in a small FIFO. It presents them to a consumer over a valid/ready handshake and keeps a saturating count of accepted words with `r` = 1. It also keeps a sticky drop flag for words offered while the buffer is full.

---
 rtl/sample04_result_fifo.sv | 119 +++++++++++
 tb/tb_sample04_result_fifo.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample04_result_fifo.sv
// -----------------------------------------------------------------------------
// sample04_result_fifo
//
// Capture stage for the sample04 scheduling circuit. It takes the result bits
// {r,s,t} when the upstream driver marks them valid and queues them in a small
// FIFO. The queue drains to a consumer over a valid/ready handshake. The block
// also keeps a saturating count of accepted words with r=1, and a sticky flag
// for words offered while the queue was full.
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 2)
//   CNT_W     width of r_count
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous active-low reset
//   in_valid   upstream offers {r,s,t} this cycle
//   r, s, t    result bits from sample04
//   in_ready   a word can be accepted this cycle (not full)
//   out_valid  head word available (not empty)
//   out_data   head word {r,s,t}; stale when out_valid is low
//   out_ready  consumer takes the head word
//   level      number of stored words
//   r_count    saturating count of pushed words with r=1
//   drop       sticky: a word was offered while full (cleared only by reset)
// -----------------------------------------------------------------------------
module sample04_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       r,
  input  logic                       s,
  input  logic                       t,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [2:0]                 out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           r_count,
  output logic                       drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Flags come only from the registered level. This keeps in_ready and
  // out_valid free of any combinational path from in_valid or out_ready.
  // A pop therefore never frees a slot for a push in the same cycle.
  assign full      = (level == LW'(DEPTH));
  assign empty     = (level == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;

  // Gating with rst makes the array ignore pushes while reset is held, just
  // as the control state does.
  assign push = rst && in_valid && in_ready;
  assign pop  = rst && out_valid && out_ready;

  // The head word is read straight from storage. A word written this cycle
  // shows up only after the edge, so there is no pass-through.
  assign out_data = mem[rd_ptr];

  // NOTE: the storage array has no reset. Pointers and level decide which
  // entries are valid, so clearing the data would add reset fan-out for no
  // benefit.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {r, s, t};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      r_count <= '0;
      drop    <= 1'b0;
    end else begin
      // Pointers are exactly AW bits wide, so they wrap from DEPTH-1 to 0
      // with no extra logic (DEPTH is a power of two).
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      // Saturate at all-ones instead of wrapping.
      if (push && r && (r_count != '1)) begin
        r_count <= r_count + CNT_W'(1);
      end

      if (in_valid && full) begin
        drop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sample04_result_fifo.sv
// -----------------------------------------------------------------------------
// tb_sample04_result_fifo
//
// Directed testbench for sample04_result_fifo. The main instance uses the
// default parameters (DEPTH=4, CNT_W=8). A second instance with CNT_W=3
// shares the same stimulus and shows r_count saturating.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at that
// same point, so everything reflects the state that edge produced.
// -----------------------------------------------------------------------------
module tb_sample04_result_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       r, s, t;
  logic       out_ready;

  logic       in_ready, out_valid, drop;
  logic [2:0] out_data;
  logic [2:0] level;
  logic [7:0] r_count;

  logic       sat_in_ready, sat_out_valid, sat_drop;
  logic [2:0] sat_out_data;
  logic [2:0] sat_level;
  logic [2:0] sat_r_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sample04_result_fifo #(.DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .r         (r),
    .s         (s),
    .t         (t),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level),
    .r_count   (r_count),
    .drop      (drop)
  );

  sample04_result_fifo #(.DEPTH(4), .CNT_W(3)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .r         (r),
    .s         (s),
    .t         (t),
    .in_ready  (sat_in_ready),
    .out_valid (sat_out_valid),
    .out_data  (sat_out_data),
    .out_ready (out_ready),
    .level     (sat_level),
    .r_count   (sat_r_count),
    .drop      (sat_drop)
  );

  // Advance one clock edge; outputs are stable on return.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [2:0] w);
    {r, s, t} = w;
  endtask

  // Push one word with no pop, then go idle.
  task automatic push_word(input logic [2:0] w);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    set_word(w);
    step();
    in_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_word(3'b000);
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (level !== 3'd0)     begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (r_count !== 8'd0)   begin failures++; $display("FAIL reset_r_count got=%0d exp=0", r_count); end
    checks++; if (drop !== 1'b0)      begin failures++; $display("FAIL reset_drop got=%b exp=0", drop); end
  endtask

  task automatic test_single_word();
    in_valid  = 1'b1;
    out_ready = 1'b0;
    set_word(3'b101);
    #1;
    // Before the capturing edge, the offered word must not be visible.
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_no_passthru got=%b exp=0", out_valid); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1)   begin failures++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 3'b101)  begin failures++; $display("FAIL single_out_data got=%b exp=101", out_data); end
    checks++; if (level !== 3'd1)       begin failures++; $display("FAIL single_level got=%0d exp=1", level); end
    checks++; if (r_count !== 8'd1)     begin failures++; $display("FAIL single_r_count got=%0d exp=1", r_count); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (level !== 3'd0)       begin failures++; $display("FAIL single_pop_level got=%0d exp=0", level); end
    checks++; if (out_valid !== 1'b0)   begin failures++; $display("FAIL single_pop_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_fill_overflow();
    logic [2:0] words [4] = '{3'b100, 3'b010, 3'b001, 3'b111};
    apply_reset();
    for (int i = 0; i < 4; i++) push_word(words[i]);
    checks++; if (level !== 3'd4)    begin failures++; $display("FAIL fill_level got=%0d exp=4", level); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
    checks++; if (r_count !== 8'd2)  begin failures++; $display("FAIL fill_r_count got=%0d exp=2", r_count); end
    checks++; if (drop !== 1'b0)     begin failures++; $display("FAIL fill_drop_early got=%b exp=0", drop); end
    push_word(3'b110);
    checks++; if (drop !== 1'b1)     begin failures++; $display("FAIL overflow_drop got=%b exp=1", drop); end
    checks++; if (level !== 3'd4)    begin failures++; $display("FAIL overflow_level got=%0d exp=4", level); end
    checks++; if (r_count !== 8'd2)  begin failures++; $display("FAIL overflow_r_count got=%0d exp=2", r_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (out_data !== words[i] || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL drain_%0d got=%b/v%b exp=%b/v1", i, out_data, out_valid, words[i]);
      end
      checks++;
      step();
    end
    checks++; if (level !== 3'd0)     begin failures++; $display("FAIL drain_level got=%0d exp=0", level); end
    // Popping while empty must not change anything.
    step();
    out_ready = 1'b0;
    checks++; if (level !== 3'd0)     begin failures++; $display("FAIL empty_pop_level got=%0d exp=0", level); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL empty_pop_out_valid got=%b exp=0", out_valid); end
    checks++; if (drop !== 1'b1)      begin failures++; $display("FAIL drop_sticky got=%b exp=1", drop); end
  endtask

  task automatic test_full_pop();
    apply_reset();
    for (int i = 0; i < 4; i++) push_word(3'(i));
    in_valid  = 1'b1;
    out_ready = 1'b1;
    set_word(3'b111);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (level !== 3'd3)      begin failures++; $display("FAIL fullpop_level got=%0d exp=3", level); end
    checks++; if (drop !== 1'b1)       begin failures++; $display("FAIL fullpop_drop got=%b exp=1", drop); end
    checks++; if (out_data !== 3'b001) begin failures++; $display("FAIL fullpop_head got=%b exp=001", out_data); end
    checks++; if (r_count !== 8'd0)    begin failures++; $display("FAIL fullpop_r_count got=%0d exp=0", r_count); end
    checks++; if (in_ready !== 1'b1)   begin failures++; $display("FAIL fullpop_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    push_word(3'd0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      set_word(3'(i % 8));
      if (out_data !== 3'((i - 1) % 8)) begin
        failures++;
        $display("FAIL stream_data_%0d got=%b exp=%b", i, out_data, 3'((i - 1) % 8));
      end
      checks++;
      step();
      if (level !== 3'd1) begin
        failures++;
        $display("FAIL stream_level_%0d got=%0d exp=1", i, level);
      end
      checks++;
    end
    in_valid = 1'b0;
    checks++; if (out_data !== 3'd2) begin failures++; $display("FAIL stream_last got=%b exp=010", out_data); end
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_saturation();
    logic [2:0] exp_sat;
    apply_reset();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    set_word(3'b100);
    for (int i = 1; i <= 9; i++) begin
      step();
      exp_sat = (i >= 7) ? 3'd7 : 3'(i);
      if (sat_r_count !== exp_sat) begin
        failures++;
        $display("FAIL sat_r_count_%0d got=%0d exp=%0d", i, sat_r_count, exp_sat);
      end
      checks++;
      if (r_count !== 8'(i)) begin
        failures++;
        $display("FAIL wide_r_count_%0d got=%0d exp=%0d", i, r_count, i);
      end
      checks++;
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    checks++; if (sat_r_count !== 3'd7) begin failures++; $display("FAIL sat_pop_hold got=%0d exp=7", sat_r_count); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 4; i++) push_word(3'b100);
    push_word(3'b100);
    out_ready = 1'b1;
    step();
    in_valid = 1'b1;
    set_word(3'b100);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (level !== 3'd3 || drop !== 1'b1 || r_count !== 8'd5) begin
      failures++;
      $display("FAIL midreset_setup got=l%0d/d%b/c%0d exp=l3/d1/c5", level, drop, r_count);
    end
    rst       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    set_word(3'b111);
    step();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL midreset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid got=%b exp=0", out_valid); end
    checks++; if (level !== 3'd0)     begin failures++; $display("FAIL midreset_level got=%0d exp=0", level); end
    checks++; if (r_count !== 8'd0)   begin failures++; $display("FAIL midreset_r_count got=%0d exp=0", r_count); end
    checks++; if (drop !== 1'b0)      begin failures++; $display("FAIL midreset_drop got=%b exp=0", drop); end
    // A push in the very first cycle after reset must be accepted.
    push_word(3'b011);
    checks++; if (out_data !== 3'b011) begin failures++; $display("FAIL postreset_data got=%b exp=011", out_data); end
    checks++; if (level !== 3'd1)      begin failures++; $display("FAIL postreset_level got=%0d exp=1", level); end
    checks++; if (r_count !== 8'd0)    begin failures++; $display("FAIL postreset_r_count got=%0d exp=0", r_count); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0)  begin failures++; $display("FAIL postreset_alone got=%b exp=0", out_valid); end
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    {r, s, t} = 3'b000;
    #1;
    test_reset();
    test_single_word();
    test_fill_overflow();
    test_full_pop();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
